esc_speed_ramp: RTL and testbench
=================================

// Module: esc_speed_ramp
// PURPOSE
// - Upstream feeder for the ESC pulse generator. Takes flight-controller motor-speed requests and drives the
//   11-bit SPEED input of one ESC interface. One instance sits in front of each motor.
// - Adds an arming sequence: zero throttle is held for ARM_FRAMES frames so the ESC can initialise.
// - Adds a per-frame slew limit so SPEED never jumps by more than STEP between PWM frames.
// PARAMETERS
// - FRAME_CYCLES  1048576  clk cycles per PWM frame; matches the 20-bit ESC period; range 2..2^20
// - STEP          32       maximum |delta SPEED| per frame; range 1..2047
// - ARM_FRAMES    50       frames of forced-zero SPEED before armed; range 1..255
// - WDOG_FRAMES   10       frames with no tgt_vld before watchdog trips (WDOG_EN only); range 1..255
// PORTS
// - clk        in   1   system clock, 50MHz
// - rst        in   1   synchronous reset, active-high
// - arm        in   1   level; 1 requests armed operation, 0 disarms immediately
// - tgt_vld    in   1   one-cycle strobe; tgt_speed is valid on this cycle
// - tgt_speed  in   11  requested motor speed, unsigned
// - SPEED      out  11  registered speed command to the ESC interface
// - armed      out  1   1 while in ARMED
// - at_tgt     out  1   1 when SPEED == effective target
// - frame_tick out  1   one-cycle pulse on the last cycle of each frame
// - wdog_trip  out  1   sticky watchdog flag; constant 0 without WDOG_EN
// BEHAVIOUR
// - Clock and reset: single clk domain. All state updates on posedge clk.
// - Reset values: rst has priority over all other inputs. On reset:
//   - SPEED=0, armed=0, at_tgt=1, frame_tick=0, wdog_trip=0
//   - target register=0, frame counter=0, arm counter=0, watchdog counter=0, state=DISARMED
// - Frame counter: 20-bit up-counter, 0..FRAME_CYCLES-1, wraps to 0.
//   - frame_tick is registered: it is 1 on the cycle the counter holds FRAME_CYCLES-1.
//   - The counter runs free in every state.
// - Target register: loads tgt_speed on any cycle with tgt_vld=1, in any state.
//   - Effective target (tgt_eff) = target register, or 0 while wdog_trip=1.
// - State machine:
//   - DISARMED: SPEED=0. arm=1 -> ARMING, arm counter cleared.
//   - ARMING: SPEED=0. Arm counter increments on each frame_tick.
//     - arm=0 -> DISARMED.
//     - On the ARM_FRAMES-th frame_tick -> ARMED, with armed=1 from the next cycle.
//   - ARMED: SPEED slews toward tgt_eff, only on frame_tick cycles (SPEED visible the next cycle):
//     - tgt_eff > SPEED: SPEED += min(STEP, tgt_eff-SPEED)
//     - tgt_eff < SPEED: SPEED -= min(STEP, SPEED-tgt_eff)
//     - Use 12-bit intermediate arithmetic. No overshoot, no wrap; SPEED stays within 0..2047.
//   - ARMED with arm=0: next cycle SPEED=0, armed=0, state=DISARMED. No ramp-down.
// - Simultaneous events:
//   - tgt_vld and frame_tick on the same cycle: the slew uses the OLD target register value.
//     The new value applies from the next frame.
//   - arm falling on a frame_tick cycle: disarm wins, SPEED=0.
// - at_tgt: combinational (SPEED == tgt_eff). It is 1 in DISARMED/ARMING only when tgt_eff==0.
// - Reset mid-operation: reset values apply on the next cycle regardless of state. Arming restarts from scratch.
// CONFIGURATION
// - Macro WDOG_EN defined: add a watchdog counter, active only in ARMED.
//   - The counter increments on each frame_tick with no tgt_vld since the last tick.
//   - tgt_vld clears the counter and wdog_trip.
//   - When the count reaches WDOG_FRAMES, wdog_trip=1 and tgt_eff=0, so SPEED ramps down at STEP/frame.
//   - Leaving ARMED clears the counter; wdog_trip holds until tgt_vld or rst.
// - Macro WDOG_EN undefined: no watchdog logic, wdog_trip tied 0, tgt_eff = target register.
// TESTING (bench params: FRAME_CYCLES=16, STEP=32, ARM_FRAMES=4, WDOG_FRAMES=3)
// - Reset: rst=1 for 2 cycles with arm=1 -> SPEED=0, armed=0, at_tgt=1, frame_tick=0, wdog_trip=0.
//   - Then frame_tick pulses every 16 cycles.
// - Arm and ramp up: arm=1, tgt_speed=100 with tgt_vld.
//   - armed=1 after the 4th frame_tick.
//   - SPEED=32,64,96,100 after the next four ticks; at_tgt=1 at 100.
// - Ramp down and saturation: from SPEED=100, tgt_speed=2047 -> SPEED reaches 2047 without wrap.
//   - Then tgt_speed=20 -> SPEED decreases 32/frame to exactly 20.
// - Disarm mid-ramp: arm=0 while SPEED=64 and rising -> next cycle SPEED=0, armed=0.
//   - Re-arm -> 4 frames of zero before ramping again.
// - Coincident strobe: tgt_vld with tgt_speed=500 on a frame_tick cycle, old target 0 at SPEED=0
//   -> SPEED stays 0 on that tick, then 32 on the following tick.
// - Watchdog (WDOG_EN): armed at SPEED=100, no tgt_vld for 3 ticks -> wdog_trip=1, SPEED 68,36,4,0.
//   - tgt_vld with 100 -> wdog_trip=0, SPEED ramps back to 100.

Source files
------------

// File: rtl/esc_speed_ramp.sv
// Speed-command conditioner in front of one ESC: arming hold-off, per-frame slew limit, frame tick.
// Optional feature: define WDOG_EN to add the missing-request watchdog (wdog_trip).
module esc_speed_ramp #(
  parameter int FRAME_CYCLES = 1048576,
  parameter int STEP         = 32,
  parameter int ARM_FRAMES   = 50,
  parameter int WDOG_FRAMES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        tgt_vld,
  input  logic [10:0] tgt_speed,
  output logic [10:0] SPEED,
  output logic        armed,
  output logic        at_tgt,
  output logic        frame_tick,
  output logic        wdog_trip
);

  typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_e;

  localparam logic [19:0] FC_LAST  = 20'(FRAME_CYCLES - 1);
  localparam logic [7:0]  ARM_LAST = 8'(ARM_FRAMES - 1);
  localparam logic [11:0] STEP12   = 12'(STEP);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        tick_q;
  logic [7:0]  armCnt_q, armCnt_d;
  logic [10:0] tgt_q;
  logic [10:0] speed_q, speed_d;
  logic [10:0] tgtEff;
  logic [10:0] slewSpd;
  logic [11:0] spd12, eff12, gap12, stepAmt12, slew12;

  always_comb begin
    cnt_d = (cnt_q == FC_LAST) ? 20'd0 : cnt_q + 20'd1;
  end

  // 12-bit slew toward the effective target; the clamp keeps any carry from wrapping SPEED
  always_comb begin
    spd12     = {1'b0, speed_q};
    eff12     = {1'b0, tgtEff};
    gap12     = 12'd0;
    stepAmt12 = 12'd0;
    slew12    = spd12;
    if (eff12 > spd12) begin
      gap12     = eff12 - spd12;
      stepAmt12 = (gap12 > STEP12) ? STEP12 : gap12;
      slew12    = spd12 + stepAmt12;
    end else if (eff12 < spd12) begin
      gap12     = spd12 - eff12;
      stepAmt12 = (gap12 > STEP12) ? STEP12 : gap12;
      slew12    = spd12 - stepAmt12;
    end
    slewSpd = slew12[11] ? 11'h7FF : slew12[10:0];
  end

  always_comb begin
    state_d  = state_q;
    armCnt_d = armCnt_q;
    speed_d  = speed_q;
    unique case (state_q)
      DISARMED: begin
        speed_d = 11'd0;
        if (arm) begin
          state_d  = ARMING;
          armCnt_d = 8'd0;
        end
      end
      ARMING: begin
        speed_d = 11'd0;
        if (!arm) begin
          state_d = DISARMED;
        end else if (tick_q) begin
          if (armCnt_q == ARM_LAST) state_d = ARMED;
          else armCnt_d = armCnt_q + 8'd1;
        end
      end
      ARMED: begin
        // Disarm drops straight to zero, even on a tick cycle
        if (!arm) begin
          state_d = DISARMED;
          speed_d = 11'd0;
        end else if (tick_q) begin
          speed_d = slewSpd;
        end
      end
      default: begin
        state_d = DISARMED;
        speed_d = 11'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DISARMED;
      cnt_q    <= 20'd0;
      tick_q   <= 1'b0;
      armCnt_q <= 8'd0;
      tgt_q    <= 11'd0;
      speed_q  <= 11'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= (cnt_d == FC_LAST);
      armCnt_q <= armCnt_d;
      if (tgt_vld) tgt_q <= tgt_speed;
      speed_q  <= speed_d;
    end
  end

`ifdef WDOG_EN
  localparam logic [7:0] WD_LIM  = 8'(WDOG_FRAMES);
  localparam logic [7:0] WD_LAST = 8'(WDOG_FRAMES - 1);

  logic [7:0] wdCnt_q, wdCnt_d;
  logic       seen_q, seen_d;
  logic       trip_q, trip_d;

  // seen_q remembers a request since the last tick, so a frame with any request never counts
  always_comb begin
    wdCnt_d = wdCnt_q;
    trip_d  = trip_q;
    seen_d  = tick_q ? 1'b0 : (seen_q | tgt_vld);
    if (state_q != ARMED || !arm) begin
      wdCnt_d = 8'd0;
    end else if (tick_q && !(seen_q || tgt_vld)) begin
      if (wdCnt_q != WD_LIM) wdCnt_d = wdCnt_q + 8'd1;
      if (wdCnt_q >= WD_LAST) trip_d = 1'b1;
    end
    if (tgt_vld) begin
      wdCnt_d = 8'd0;
      trip_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdCnt_q <= 8'd0;
      seen_q  <= 1'b0;
      trip_q  <= 1'b0;
    end else begin
      wdCnt_q <= wdCnt_d;
      seen_q  <= seen_d;
      trip_q  <= trip_d;
    end
  end

  assign tgtEff    = trip_q ? 11'd0 : tgt_q;
  assign wdog_trip = trip_q;
`else
  assign tgtEff    = tgt_q;
  assign wdog_trip = 1'b0;
`endif

  assign SPEED      = speed_q;
  assign armed      = (state_q == ARMED);
  assign at_tgt     = (speed_q == tgtEff);
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_esc_speed_ramp.sv
// Bench for esc_speed_ramp: frame-level behavioural model checked every cycle, plus directed literal checks.
// Watchdog scenarios are included when WDOG_EN is defined.
module tb_esc_speed_ramp;

  localparam int FC   = 16;
  localparam int STEP = 32;
  localparam int AF   = 4;
  localparam int WF   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        tgt_vld;
  logic [10:0] tgt_speed;
  logic [10:0] SPEED;
  logic        armed;
  logic        at_tgt;
  logic        frame_tick;
  logic        wdog_trip;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;
  bit keepAlive = 1'b1;
  int curTgt = 0;

  // model: mode 0=off, 1=waiting out arm frames, 2=running
  int m_mode = 0, m_speed = 0, m_frames = 0, m_cyc = 0, m_tgt = 0;
  int m_trip = 0, m_wcnt = 0, m_seen = 0;
  int tick, eff;
  bit runningBefore;

  esc_speed_ramp #(
    .FRAME_CYCLES(FC),
    .STEP(STEP),
    .ARM_FRAMES(AF),
    .WDOG_FRAMES(WF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .tgt_vld(tgt_vld),
    .tgt_speed(tgt_speed),
    .SPEED(SPEED),
    .armed(armed),
    .at_tgt(at_tgt),
    .frame_tick(frame_tick),
    .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_speed = 0; m_frames = 0; m_cyc = 0; m_tgt = 0;
      m_trip = 0; m_wcnt = 0; m_seen = 0;
    end else begin
      tick = (m_cyc == FC - 1) ? 1 : 0;
      eff = (m_trip != 0) ? 0 : m_tgt;
      runningBefore = (m_mode == 2);
      if (!arm) begin
        m_mode = 0;
        m_speed = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        m_frames = 0;
      end else if (m_mode == 1) begin
        if (tick != 0) begin
          m_frames = m_frames + 1;
          if (m_frames == AF) m_mode = 2;
        end
      end else if (tick != 0) begin
        if (eff > m_speed) m_speed = m_speed + ((eff - m_speed < STEP) ? eff - m_speed : STEP);
        else if (eff < m_speed) m_speed = m_speed - ((m_speed - eff < STEP) ? m_speed - eff : STEP);
      end
`ifdef WDOG_EN
      if (!(runningBefore && arm)) m_wcnt = 0;
      else if (tick != 0 && m_seen == 0 && !tgt_vld) begin
        m_wcnt = (m_wcnt + 1 > WF) ? WF : m_wcnt + 1;
        if (m_wcnt >= WF) m_trip = 1;
      end
      if (tgt_vld) begin
        m_wcnt = 0;
        m_trip = 0;
      end
      m_seen = (tick != 0) ? 0 : ((m_seen != 0 || tgt_vld) ? 1 : 0);
`endif
      if (tgt_vld) m_tgt = int'(tgt_speed);
      m_cyc = (m_cyc + 1) % FC;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("SPEED", int'(SPEED), m_speed);
      checkOutput("armed", int'(armed), (m_mode == 2) ? 1 : 0);
      checkOutput("at_tgt", int'(at_tgt), (m_speed == ((m_trip != 0) ? 0 : m_tgt)) ? 1 : 0);
      checkOutput("frame_tick", int'(frame_tick), (m_cyc == FC - 1) ? 1 : 0);
      checkOutput("wdog_trip", int'(wdog_trip), m_trip);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Loads a target away from a tick cycle so the next tick already uses it
  task automatic setTarget(input int value);
    if (m_cyc == FC - 1) stepCycle();
    curTgt = value;
    tgt_vld = 1'b1;
    tgt_speed = 11'(value);
    stepCycle();
    tgt_vld = 1'b0;
  endtask

  // Advances just past the next frame tick, refreshing the target meanwhile when keepAlive is set
  task automatic waitTick();
    for (int n = 0; n < 3 * FC; n++) begin
      if (m_cyc == FC - 1) begin
        stepCycle();
        return;
      end
      if (keepAlive) begin
        tgt_vld = 1'b1;
        tgt_speed = 11'(curTgt);
      end
      stepCycle();
      tgt_vld = 1'b0;
    end
    checkOutput("waitTick_timeout", 1, 0);
  endtask

  task automatic applyStimulus(input int cycles, input int vldOdds);
    for (int n = 0; n < cycles; n++) begin
      if ($urandom_range(149) == 0) arm = ~arm;
      rst = ($urandom_range(399) == 0);
      tgt_vld = ($urandom_range(vldOdds - 1) == 0);
      tgt_speed = ($urandom_range(3) == 0) ? 11'h7FF : 11'($urandom_range(2047));
      stepCycle();
    end
    rst = 1'b0;
    tgt_vld = 1'b0;
  endtask

  initial begin
    int ramp[4];
    rst = 1'b1;
    arm = 1'b1;
    tgt_vld = 1'b0;
    tgt_speed = 11'd0;
    stepCycle();
    checkEn = 1'b1;
    stepCycle();
    checkOutput("rst_SPEED", int'(SPEED), 0);
    checkOutput("rst_armed", int'(armed), 0);
    checkOutput("rst_at_tgt", int'(at_tgt), 1);
    checkOutput("rst_frame_tick", int'(frame_tick), 0);
    checkOutput("rst_wdog_trip", int'(wdog_trip), 0);

    rst = 1'b0;
    curTgt = 100;
    tgt_vld = 1'b1;
    tgt_speed = 11'd100;
    stepCycle();
    tgt_vld = 1'b0;
    for (int i = 0; i < 13; i++) stepCycle();
    checkOutput("tick_before", int'(frame_tick), 0);
    stepCycle();
    checkOutput("tick_first", int'(frame_tick), 1);
    stepCycle();
    checkOutput("tick_after", int'(frame_tick), 0);

    for (int i = 2; i <= AF; i++) begin
      waitTick();
      checkOutput("arm_frames", int'(armed), (i == AF) ? 1 : 0);
    end
    ramp = '{32, 64, 96, 100};
    for (int i = 0; i < 4; i++) begin
      waitTick();
      checkOutput("ramp_up", int'(SPEED), ramp[i]);
    end
    checkOutput("ramp_at_tgt", int'(at_tgt), 1);

    setTarget(2047);
    for (int i = 0; i < 61; i++) waitTick();
    checkOutput("ramp_to_max", int'(SPEED), 2047);
    waitTick();
    checkOutput("hold_max", int'(SPEED), 2047);
    setTarget(20);
    for (int i = 0; i < 63; i++) waitTick();
    checkOutput("ramp_down_31", int'(SPEED), 31);
    waitTick();
    checkOutput("ramp_down_20", int'(SPEED), 20);

    setTarget(0);
    waitTick();
    setTarget(200);
    waitTick();
    waitTick();
    checkOutput("mid_ramp", int'(SPEED), 64);
    arm = 1'b0;
    stepCycle();
    checkOutput("disarm_SPEED", int'(SPEED), 0);
    checkOutput("disarm_armed", int'(armed), 0);

    setTarget(0);
    arm = 1'b1;
    stepCycle();
    for (int i = 1; i <= AF; i++) begin
      waitTick();
      checkOutput("rearm_zero", int'(SPEED), 0);
      checkOutput("rearm_armed", int'(armed), (i == AF) ? 1 : 0);
    end

    for (int n = 0; n < 2 * FC && m_cyc != FC - 1; n++) stepCycle();
    curTgt = 500;
    tgt_vld = 1'b1;
    tgt_speed = 11'd500;
    stepCycle();
    tgt_vld = 1'b0;
    checkOutput("coincident_old", int'(SPEED), 0);
    waitTick();
    checkOutput("coincident_new", int'(SPEED), 32);

`ifdef WDOG_EN
    setTarget(100);
    for (int i = 0; i < 10 && m_speed != 100; i++) waitTick();
    checkOutput("wd_start", int'(SPEED), 100);
    keepAlive = 1'b0;
    for (int i = 0; i < WF; i++) waitTick();
    checkOutput("wd_trip", int'(wdog_trip), 1);
    checkOutput("wd_hold", int'(SPEED), 100);
    ramp = '{68, 36, 4, 0};
    for (int i = 0; i < 4; i++) begin
      waitTick();
      checkOutput("wd_ramp_down", int'(SPEED), ramp[i]);
    end
    keepAlive = 1'b1;
    setTarget(100);
    checkOutput("wd_clear", int'(wdog_trip), 0);
    ramp = '{32, 64, 96, 100};
    for (int i = 0; i < 4; i++) begin
      waitTick();
      checkOutput("wd_recover", int'(SPEED), ramp[i]);
    end
`endif

    applyStimulus(2000, 8);
    applyStimulus(2000, 64);

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
